// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the DataMem port arbiter: FSM encoding, alignment mask and
// the starvation-counter width helper.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StAck  = 2'd2
  } arb_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'(WORD_BYTES - 1);

  // A zero maximum still needs one counter bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags cnt == MAX.
module sat_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares DataMem between the MEM stage (fixed priority) and a debug/loader port; a
// starvation counter forces one stalled CPU cycle so the debug access always completes.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = cnt_width(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic            cpu_busy, misaligned, grant, at_max, cnt_clr, cnt_inc;
  logic [CntW-1:0] wait_cnt;

  assign cpu_busy   = cpu_rd | cpu_wr;
  assign misaligned = (dbg_addr[1:0] & ALIGN_MASK) != 2'b00;
  assign grant      = (state_q == StPend) && (!cpu_busy || at_max);
  assign cpu_rdata  = mem_rdata;

  sat_counter #(
    .MAX (MAX_WAIT),
    .W   (CntW)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (wait_cnt),
    .at_max (at_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          cnt_clr = 1'b1;
          state_d = misaligned ? StAck : StPend;
        end
      end
      StPend: begin
        if (grant) state_d = StAck;
        else       cnt_inc = 1'b1;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The debug access displaces the CPU only in its grant cycle; a busy CPU then retries.
  always_comb begin
    mem_rd    = cpu_rd;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (grant) begin
      mem_rd    = !req_we_q;
      mem_wr    = req_we_q;
      mem_addr  = req_addr_q;
      mem_wdata = req_wdata_q;
      cpu_stall = cpu_busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      dbg_ack     <= 1'b0;
      dbg_err     <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && dbg_req) begin
        req_we_q    <= dbg_we;
        req_addr_q  <= dbg_addr;
        req_wdata_q <= dbg_wdata;
      end
      dbg_ack <= (state_d == StAck);
      dbg_err <= (state_q == StIdle) && dbg_req && misaligned;
      if (grant && !req_we_q) dbg_rdata <= mem_rdata;
    end
  end

endmodule
